// File: rtl/fifo_pack_8to16.sv
// Byte-to-word packing FIFO: pairs consecutive bytes little-endian into 16-bit words
// held in a simple dual-port RAM, read out through a registered Dout.
module fifo_pack_8to16 #(
  parameter int Wdata_Width = 8,
  parameter int Rdata_Width = 16,
  parameter int Addr_Width  = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [Wdata_Width-1:0] Din,
  input  logic                   Wen,
  output logic [Rdata_Width-1:0] Dout,
  input  logic                   Ren,
  output logic                   Dout_Valid,
  input  logic                   Flush,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Half,
  output logic [Addr_Width:0]    Word_Cnt
);

  localparam int DEPTH = 2 ** Addr_Width;
  localparam logic [Addr_Width:0] CNT_DEPTH = (Addr_Width + 1)'(DEPTH);
  localparam logic [Addr_Width:0] CNT_ONE   = (Addr_Width + 1)'(1);

  logic [Rdata_Width-1:0] r_mem [DEPTH];
  logic [Addr_Width-1:0]  r_wr_ptr;
  logic [Addr_Width-1:0]  r_rd_ptr;
  logic [Addr_Width:0]    r_cnt;
  logic                   r_half;
  logic [Wdata_Width-1:0] r_hold;
  logic [Rdata_Width-1:0] r_dout;
  logic                   r_dout_valid;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_push;
  logic w_rd_acc;

  // Request semantics: a write is taken on any edge where Wen=1 and Full=0, a read on
  // any edge where Ren=1 and Empty=0; Flush masks both. Refused requests are dropped,
  // never queued, and the read data appears with Dout_Valid one cycle later.
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_DEPTH) && r_half;
  assign w_wr_acc = Wen && !w_full && !Flush;
  assign w_push   = w_wr_acc && r_half;
  assign w_rd_acc = Ren && !w_empty && !Flush;

  // Storage is not reset; only pointers and counts define its contents.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {Din, r_hold};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_half       <= 1'b0;
      r_hold       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (Flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_half       <= 1'b0;
      r_hold       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_wr_acc) begin
        if (!r_half) begin
          r_hold <= Din;
          r_half <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_half   <= 1'b0;
        end
      end
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign Dout       = r_dout;
  assign Dout_Valid = r_dout_valid;
  assign Empty      = w_empty;
  assign Full       = w_full;
  assign Half       = r_half;
  assign Word_Cnt   = r_cnt;

endmodule

// File: tb/tb_fifo_pack_8to16.sv
// Directed bench for fifo_pack_8to16: packing order, full/empty corners, pointer wrap,
// flush and asynchronous reset, with an expected-word queue for the streaming phase.
module tb_fifo_pack_8to16;

  logic        Clk;
  logic        Rst;
  logic [7:0]  Din;
  logic        Wen;
  logic [15:0] Dout;
  logic        Ren;
  logic        Dout_Valid;
  logic        Flush;
  logic        Empty;
  logic        Full;
  logic        Half;
  logic [4:0]  Word_Cnt;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  fifo_pack_8to16 dut (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Wen(Wen), .Dout(Dout), .Ren(Ren),
    .Dout_Valid(Dout_Valid), .Flush(Flush), .Empty(Empty), .Full(Full),
    .Half(Half), .Word_Cnt(Word_Cnt)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int cnt, input bit e, input bit f,
                             input bit h);
    check({tag, ".cnt"}, 32'(Word_Cnt), 32'(cnt));
    check({tag, ".empty"}, 32'(Empty), 32'(e));
    check({tag, ".full"}, 32'(Full), 32'(f));
    check({tag, ".half"}, 32'(Half), 32'(h));
  endtask

  // drivers: apply inputs, take one rising edge, settle before sampling
  task automatic cycle(input bit wen, input logic [7:0] din, input bit ren, input bit flush);
    Wen = wen; Din = din; Ren = ren; Flush = flush;
    @(posedge Clk);
    #1;
    Wen = 1'b0; Ren = 1'b0; Flush = 1'b0; Din = 8'h00;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] exp);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check({tag, ".valid"}, 32'(Dout_Valid), 32'd1);
    check({tag, ".dout"}, 32'(Dout), 32'(exp));
  endtask

  initial begin
    logic [7:0] lo;
    logic [7:0] hi;
    logic [15:0] w;
    total = 0;
    bad = 0;
    Rst = 1'b1; Din = 8'h00; Wen = 1'b0; Ren = 1'b0; Flush = 1'b0;
    @(posedge Clk);
    #1;
    check("rst.dout", 32'(Dout), 32'h0);
    check("rst.valid", 32'(Dout_Valid), 32'd0);
    check_flags("rst", 0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;

    // first pair and a single read
    wr_byte(8'h11);
    check_flags("w11", 0, 1'b1, 1'b0, 1'b1);
    wr_byte(8'h22);
    check_flags("w22", 1, 1'b0, 1'b0, 1'b0);
    rd_check("r2211", 16'h2211);
    check_flags("r2211", 0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("hold.valid", 32'(Dout_Valid), 32'd0);
    check("hold.dout", 32'(Dout), 32'h2211);

    // fill to 16 words, then an odd byte reaches Full
    for (int i = 0; i < 32; i++) wr_byte(8'(i));
    check_flags("fill32", 16, 1'b0, 1'b0, 1'b0);
    wr_byte(8'h20);
    check_flags("fill33", 16, 1'b0, 1'b1, 1'b1);
    wr_byte(8'hFF);
    check_flags("drop_ff", 16, 1'b0, 1'b1, 1'b1);

    // write+read at Full: write refused, oldest word read
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_rw.valid", 32'(Dout_Valid), 32'd1);
    check("full_rw.dout", 32'(Dout), 32'h0100);
    check_flags("full_rw", 15, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 16; k++) begin
      w = {8'(2 * k + 1), 8'(2 * k)};
      rd_check($sformatf("drain%0d", k), w);
    end
    check_flags("drained", 0, 1'b1, 1'b0, 1'b1);

    // empty with Half=1: push succeeds, read refused
    cycle(1'b1, 8'h21, 1'b1, 1'b0);
    check("empty_rw.valid", 32'(Dout_Valid), 32'd0);
    check_flags("empty_rw", 1, 1'b0, 1'b0, 1'b0);
    rd_check("r2120", 16'h2120);

    // streaming with continuous reads; pointers wrap four times
    for (int i = 0; i < 64; i++) begin
      lo = 8'(i * 3 + 5);
      hi = 8'(255 - i);
      cycle(1'b1, lo, 1'b1, 1'b0);
      check("stream_lo.cnt", 32'(Word_Cnt), 32'd0);
      if (i > 0) begin
        check("stream.valid", 32'(Dout_Valid), 32'd1);
        if (exp_q.size() == 0) check("stream.q_underflow", 32'd1, 32'd0);
        else check($sformatf("stream.dout%0d", i - 1), 32'(Dout), 32'(exp_q.pop_front()));
      end else begin
        check("stream_first.valid", 32'(Dout_Valid), 32'd0);
      end
      cycle(1'b1, hi, 1'b1, 1'b0);
      exp_q.push_back({hi, lo});
      check("stream_hi.cnt", 32'(Word_Cnt), 32'd1);
      check("stream_hi.valid", 32'(Dout_Valid), 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_last.valid", 32'(Dout_Valid), 32'd1);
    if (exp_q.size() == 0) check("stream_last.q_underflow", 32'd1, 32'd0);
    else check("stream_last.dout", 32'(Dout), 32'(exp_q.pop_front()));
    check("stream.q_left", 32'(exp_q.size()), 32'd0);
    check_flags("stream_end", 0, 1'b1, 1'b0, 1'b0);

    // flush with Wen=1 discards everything, including the flush-cycle byte
    wr_byte(8'h01);
    wr_byte(8'h02);
    wr_byte(8'h03);
    check_flags("pre_flush", 1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h04, 1'b0, 1'b1);
    check_flags("flush", 0, 1'b1, 1'b0, 1'b0);
    check("flush.dout", 32'(Dout), 32'h0);
    check("flush.valid", 32'(Dout_Valid), 32'd0);
    wr_byte(8'h05);
    wr_byte(8'h06);
    rd_check("post_flush", 16'h0605);

    // asynchronous reset between edges
    wr_byte(8'h09);
    wr_byte(8'h0A);
    wr_byte(8'h0B);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst.dout", 32'(Dout), 32'h0A09);
    check_flags("pre_rst", 0, 1'b1, 1'b0, 1'b1);
    #2;
    Rst = 1'b1;
    #1;
    check("arst.dout", 32'(Dout), 32'h0);
    check("arst.valid", 32'(Dout_Valid), 32'd0);
    check_flags("arst", 0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    wr_byte(8'h0C);
    wr_byte(8'h0D);
    check_flags("post_rst", 1, 1'b0, 1'b0, 1'b0);
    rd_check("post_rst", 16'h0D0C);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pack_8to16.md
Name: fifo_pack_8to16

Overview:
- Single-clock, width-up-converting FIFO: 8-bit byte writes, 16-bit word reads.
- Pairs consecutive bytes into little-endian words. The first byte of each pair lands in bits [7:0]; the second lands in bits [15:8].
- Sits on the write side of the SDRAM controller datapath. It packs byte streams into controller-width words before burst writes.
- It is the counterpart to the existing 16-to-8 unpacking read FIFO.

Parameters:
- Wdata_Width, 8, write (byte) data width. Must equal Rdata_Width/2.
- Rdata_Width, 16, read (word) data width.
- Addr_Width, 4, word-storage address width. Depth is DEPTH = 2**Addr_Width words (16).

Ports:
- Clk  in  1  single clock; all logic is rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- Din  in  Wdata_Width  write byte.
- Wen  in  1  write request.
- Dout  out  Rdata_Width  read word, registered.
- Ren  in  1  read request.
- Dout_Valid  out  1  one-cycle pulse; Dout is updated this cycle.
- Flush  in  1  synchronous clear of all contents.
- Empty  out  1  no complete word stored.
- Full  out  1  no byte can be accepted.
- Half  out  1  one unpaired byte is held in the pack register.
- Word_Cnt  out  Addr_Width+1  number of complete words stored.

Behaviour:
- Reset (Rst=1, asynchronous):
  - Pointers, Word_Cnt, Half, Dout_Valid = 0.
  - Dout = 0, Empty = 1, Full = 0.
  - Hold byte = 0.
  - RAM contents are don't-care.
- Flush (sync, highest priority after Rst): same end state as reset, in the next cycle. Wen and Ren in a Flush cycle are ignored.
- Write accepted when Wen && !Full:
  - If Half=0: Din goes to the hold register; Half becomes 1.
  - If Half=1: word {Din, hold} is written at wr_ptr; wr_ptr++; Half becomes 0.
  - Wen while Full is silently dropped; no state change.
- Read accepted when Ren && !Empty:
  - Word at rd_ptr is loaded into Dout on the next edge; rd_ptr++.
  - Dout_Valid = 1 for exactly that cycle (1-cycle latency).
  - Ren while Empty: no change, Dout_Valid = 0.
  - Dout holds its last value when no read occurs.
- Word_Cnt:
  - +1 on a word push only.
  - −1 on a read only.
  - Unchanged when a push and a read occur in the same cycle.
- Flags, all combinational from registered state:
  - Empty = (Word_Cnt == 0).
  - Full = (Word_Cnt == DEPTH) && Half.
  - With Word_Cnt == DEPTH and Half = 0, one more byte is accepted into the hold register.
- Simultaneous read and write when Full: the write is still rejected (no fall-through). The read proceeds; Full deasserts the next cycle.
- Simultaneous read and write when Empty with Half=1: the word pushes. The read is rejected because Empty was 1 that cycle. Empty deasserts the next cycle.
- Pointers are Addr_Width bits and wrap naturally from DEPTH−1 to 0.
- A held odd byte is never emitted until its partner arrives. Flush discards it.
- Storage is a simple dual-port RAM: synchronous write, synchronous read. It may be inferred or instantiated.

Test Plan:
- Reset then write 0x11, 0x22 -> Half=1 after the 1st write, 0 after the 2nd. Word_Cnt=1, Empty=0. Ren -> next cycle Dout=0x2211, Dout_Valid=1.
- Write 33 bytes 0x00..0x20 with no reads -> after 32 bytes Word_Cnt=16, Full=0. After byte 33, Half=1 and Full=1. A 34th byte 0xFF is dropped. 16 reads return 0x0100, 0x0302 … 0x1F1E. Then Empty=1, Half=1.
- At Full, assert Wen and Ren together with Din=0xAA -> read returns the oldest word, 0xAA is dropped, Word_Cnt=15, Full=0 the next cycle.
- Stream 64 byte pairs while reading continuously -> pointers wrap 4 times. Every word matches a scoreboard, and Word_Cnt never exceeds 1.
- Write 3 bytes, then Flush with Wen=1 -> Word_Cnt=0, Half=0, Empty=1. The flush-cycle byte is not stored.
- Assert Rst asynchronously mid-stream between edges -> all outputs go to their reset values immediately, without waiting for a clock edge. The FIFO operates normally after deassertion.
